// File: rtl/change_dispenser_if.sv
// Bus between the refund controller, the change dispenser and the coin ejector.
// The slave modport is the dispenser's view; master is the controller/ejector side.
interface change_dispenser_if #(
    parameter int AMT_W = 11,
    parameter int CNT_W = 8
);
    logic             refund_valid;
    logic [AMT_W-1:0] refund_amount;
    logic             refund_ready;
    logic [3:0]       stock_empty;
    logic             eject_req;
    logic [1:0]       coin_out;
    logic             eject_ack;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] shortfall;
    logic [CNT_W-1:0] coins_dispensed;
    logic             fault;

    modport slave (
        input  refund_valid, refund_amount, stock_empty, eject_ack,
        output refund_ready, eject_req, coin_out, busy, done,
               shortfall, coins_dispensed, fault
    );

    modport master (
        output refund_valid, refund_amount, stock_empty, eject_ack,
        input  refund_ready, eject_req, coin_out, busy, done,
               shortfall, coins_dispensed, fault
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: ejects 100/50/20/10 coins over a 4-phase req/ack
// handshake, skips empty tubes, reports the undispensable remainder as shortfall.
module change_dispenser #(
    parameter int AMT_W   = 11,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    change_dispenser_if.slave bus
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_REQ    = 3'd2,
        S_REL    = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AMT_W-1:0] r_remaining;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_coins;
    logic [AMT_W-1:0] r_shortfall;
    logic [1:0]       r_coin_out;
    logic             r_eject_req;
    logic             r_busy;
    logic             r_ready;
    logic             r_done;
    logic             r_fault;
    logic             w_found;
    logic [1:0]       w_code;
    logic             w_timeout;

    // Coin code to credit value: 0=10, 1=20, 3=50, 2=100.
    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] code);
        logic [AMT_W-1:0] v;
        case (code)
            2'd0:    v = AMT_W'(7'd10);
            2'd1:    v = AMT_W'(7'd20);
            2'd2:    v = AMT_W'(7'd100);
            2'd3:    v = AMT_W'(7'd50);
            default: v = AMT_W'(7'd0);
        endcase
        return v;
    endfunction

    assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));

    // Greedy pick of the largest stocked coin that still fits the remainder.
    always_comb begin
        w_found = 1'b0;
        w_code  = 2'd0;
        if ((r_remaining >= coin_value(2'd2)) && !bus.stock_empty[2]) begin
            w_found = 1'b1;
            w_code  = 2'd2;
        end else if ((r_remaining >= coin_value(2'd3)) && !bus.stock_empty[3]) begin
            w_found = 1'b1;
            w_code  = 2'd3;
        end else if ((r_remaining >= coin_value(2'd1)) && !bus.stock_empty[1]) begin
            w_found = 1'b1;
            w_code  = 2'd1;
        end else if ((r_remaining >= coin_value(2'd0)) && !bus.stock_empty[0]) begin
            w_found = 1'b1;
            w_code  = 2'd0;
        end else begin
            w_found = 1'b0;
            w_code  = 2'd0;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; ack wins over a timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.refund_valid) w_state_nxt = S_SELECT;
                else                  w_state_nxt = S_IDLE;
            end
            S_SELECT: begin
                if (w_found) w_state_nxt = S_REQ;
                else         w_state_nxt = S_DONE;
            end
            S_REQ: begin
                if (bus.eject_ack)   w_state_nxt = S_REL;
                else if (w_timeout)  w_state_nxt = S_FAULT;
                else                 w_state_nxt = S_REQ;
            end
            S_REL: begin
                if (!bus.eject_ack)  w_state_nxt = S_SELECT;
                else if (w_timeout)  w_state_nxt = S_FAULT;
                else                 w_state_nxt = S_REL;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Refund datapath: remainder, handshake timer, coin count, shortfall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_remaining <= {AMT_W{1'b0}};
            r_timer     <= {TMR_W{1'b0}};
            r_coins     <= {CNT_W{1'b0}};
            r_shortfall <= {AMT_W{1'b0}};
            r_coin_out  <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.refund_valid) begin
                        r_remaining <= bus.refund_amount;
                        r_coins     <= {CNT_W{1'b0}};
                        r_shortfall <= {AMT_W{1'b0}};
                    end
                end
                S_SELECT: begin
                    r_timer <= {TMR_W{1'b0}};
                    if (w_found) r_coin_out  <= w_code;
                    else         r_shortfall <= r_remaining;
                end
                S_REQ: begin
                    if (bus.eject_ack) begin
                        r_remaining <= r_remaining - coin_value(r_coin_out);
                        r_timer     <= {TMR_W{1'b0}};
                        if (r_coins != {CNT_W{1'b1}}) r_coins <= r_coins + CNT_W'(1'b1);
                    end else if (w_timeout) begin
                        r_shortfall <= r_remaining;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1'b1);
                    end
                end
                S_REL: begin
                    if (bus.eject_ack) begin
                        if (w_timeout) r_shortfall <= r_remaining;
                        else           r_timer     <= r_timer + TMR_W'(1'b1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_eject_req <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_eject_req <= (w_state_nxt == S_REQ);
            r_busy      <= (w_state_nxt == S_SELECT) || (w_state_nxt == S_REQ) ||
                           (w_state_nxt == S_REL);
            r_ready     <= (w_state_nxt == S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            r_fault     <= (w_state_nxt == S_FAULT);
        end
    end

    assign bus.eject_req       = r_eject_req;
    assign bus.coin_out        = r_coin_out;
    assign bus.busy            = r_busy;
    assign bus.refund_ready    = r_ready;
    assign bus.done            = r_done;
    assign bus.fault           = r_fault;
    assign bus.shortfall       = r_shortfall;
    assign bus.coins_dispensed = r_coins;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy order, empty tubes, remainders,
// ejector timeout and asynchronous reset during a dispense.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    change_dispenser_if #(.AMT_W(11), .CNT_W(8)) bus ();

    change_dispenser #(.AMT_W(11), .TIMEOUT(16), .CNT_W(8)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad = 0;
    int log_coins [8];
    int n_log;
    int done_cyc;
    int first_req_cyc;
    logic timed_out;

    // Issue one refund and act as the ejector (ack dly cycles after a req is seen).
    task automatic do_refund(input logic [10:0] amt, input logic [3:0] stock, input int dly);
        int wait_c;
        int cyc;
        logic fin;
        n_log = 0; done_cyc = -1; first_req_cyc = -1; wait_c = 0; fin = 1'b0;
        @(negedge clk);
        bus.refund_amount = amt; bus.stock_empty = stock; bus.refund_valid = 1'b1;
        @(negedge clk);
        bus.refund_valid = 1'b0;
        cyc = 1;
        while (!fin && cyc < 500) begin
            if (bus.done) begin
                done_cyc = cyc; fin = 1'b1;
            end else if (bus.eject_req && !bus.eject_ack) begin
                if (wait_c == 0) begin
                    if (n_log < 8) log_coins[n_log] = int'(bus.coin_out);
                    n_log++;
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                end
                if (wait_c >= dly) begin bus.eject_ack = 1'b1; wait_c = 0; end
                else wait_c++;
            end else if (!bus.eject_req && bus.eject_ack) begin
                bus.eject_ack = 1'b0;
            end
            if (!fin) begin @(negedge clk); cyc++; end
        end
        timed_out = !fin;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.refund_valid = 1'b0; bus.refund_amount = 11'd0;
        bus.stock_empty = 4'b0000; bus.eject_ack = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.refund_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.refund_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.eject_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.eject_req); end
        total++; if (bus.done !== 1'b0 || bus.fault !== 1'b0) begin bad++; $display("FAIL reset_done_fault got=%b%b want=00", bus.done, bus.fault); end
        total++; if (bus.shortfall !== 11'd0 || bus.coins_dispensed !== 8'd0 || bus.coin_out !== 2'd0) begin
            bad++; $display("FAIL reset_regs short=%0d coins=%0d code=%0d want 0 0 0", bus.shortfall, bus.coins_dispensed, bus.coin_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_greedy_180();
        int exp_c [4] = '{2, 3, 1, 0};
        do_refund(11'd180, 4'b0000, 2);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL g180_done_seen got=no want=yes"); end
        total++; if (n_log !== 4) begin bad++; $display("FAIL g180_ncoins got=%0d want=4", n_log); end
        for (int i = 0; i < 4; i++) begin
            total++; if (log_coins[i] !== exp_c[i]) begin bad++; $display("FAIL g180_coin%0d got=%0d want=%0d", i, log_coins[i], exp_c[i]); end
        end
        total++; if (first_req_cyc !== 2) begin bad++; $display("FAIL g180_first_req_cycle got=%0d want=2", first_req_cyc); end
        total++; if (bus.shortfall !== 11'd0) begin bad++; $display("FAIL g180_shortfall got=%0d want=0", bus.shortfall); end
        total++; if (bus.coins_dispensed !== 8'd4) begin bad++; $display("FAIL g180_count got=%0d want=4", bus.coins_dispensed); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL g180_busy_in_done got=%b want=0", bus.busy); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0 || bus.refund_ready !== 1'b1) begin
            bad++; $display("FAIL g180_done_pulse done=%b ready=%b want 0 1", bus.done, bus.refund_ready); end
    endtask

    task automatic test_skip_empty_60();
        do_refund(11'd60, 4'b1000, 1);
        total++; if (timed_out !== 1'b0 || n_log !== 3) begin bad++; $display("FAIL s60_ncoins got=%0d want=3", n_log); end
        for (int i = 0; i < 3; i++) begin
            total++; if (log_coins[i] !== 1) begin bad++; $display("FAIL s60_coin%0d got=%0d want=1", i, log_coins[i]); end
        end
        total++; if (bus.shortfall !== 11'd0) begin bad++; $display("FAIL s60_shortfall got=%0d want=0", bus.shortfall); end
        total++; if (bus.coins_dispensed !== 8'd3) begin bad++; $display("FAIL s60_count got=%0d want=3", bus.coins_dispensed); end
        @(negedge clk);
    endtask

    task automatic test_remainder_35();
        do_refund(11'd35, 4'b0000, 0);
        total++; if (timed_out !== 1'b0 || n_log !== 2) begin bad++; $display("FAIL r35_ncoins got=%0d want=2", n_log); end
        total++; if (log_coins[0] !== 1 || log_coins[1] !== 0) begin
            bad++; $display("FAIL r35_coins got=%0d,%0d want=1,0", log_coins[0], log_coins[1]); end
        total++; if (bus.shortfall !== 11'd5) begin bad++; $display("FAIL r35_shortfall got=%0d want=5", bus.shortfall); end
        total++; if (bus.coins_dispensed !== 8'd2) begin bad++; $display("FAIL r35_count got=%0d want=2", bus.coins_dispensed); end
        @(negedge clk);
    endtask

    task automatic test_no_coin();
        do_refund(11'd100, 4'b1111, 0);
        total++; if (done_cyc !== 2 || n_log !== 0) begin bad++; $display("FAIL empty100_timing done_cyc=%0d reqs=%0d want 2 0", done_cyc, n_log); end
        total++; if (bus.shortfall !== 11'd100) begin bad++; $display("FAIL empty100_shortfall got=%0d want=100", bus.shortfall); end
        total++; if (bus.coins_dispensed !== 8'd0) begin bad++; $display("FAIL empty100_count got=%0d want=0", bus.coins_dispensed); end
        @(negedge clk);
        do_refund(11'd0, 4'b0000, 0);
        total++; if (done_cyc !== 2 || n_log !== 0) begin bad++; $display("FAIL zero_timing done_cyc=%0d reqs=%0d want 2 0", done_cyc, n_log); end
        total++; if (bus.shortfall !== 11'd0) begin bad++; $display("FAIL zero_shortfall got=%0d want=0", bus.shortfall); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        int done_seen;
        @(negedge clk);
        bus.refund_amount = 11'd150; bus.stock_empty = 4'b0000; bus.refund_valid = 1'b1;
        @(negedge clk);
        bus.refund_valid = 1'b0;
        cyc = 0;
        // Ack the 100 coin, then stop once the 50 coin is being requested.
        while (cyc < 40 && !(bus.coins_dispensed == 8'd1 && bus.eject_req && !bus.eject_ack)) begin
            if (bus.eject_req && !bus.eject_ack) bus.eject_ack = 1'b1;
            else if (!bus.eject_req && bus.eject_ack) bus.eject_ack = 1'b0;
            @(negedge clk); cyc++;
        end
        total++; if (bus.eject_req !== 1'b1 || bus.coins_dispensed !== 8'd1) begin
            bad++; $display("FAIL rmid_setup req=%b coins=%0d want 1 1", bus.eject_req, bus.coins_dispensed); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.eject_req !== 1'b0 || bus.busy !== 1'b0 || bus.refund_ready !== 1'b1) begin
            bad++; $display("FAIL rmid_outputs req=%b busy=%b ready=%b want 0 0 1", bus.eject_req, bus.busy, bus.refund_ready); end
        total++; if (bus.coins_dispensed !== 8'd0 || bus.shortfall !== 11'd0) begin
            bad++; $display("FAIL rmid_counters coins=%0d short=%0d want 0 0", bus.coins_dispensed, bus.shortfall); end
        bus.eject_ack = 1'b0;
        done_seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d pulses want=0", done_seen); end
    endtask

    task automatic test_timeout();
        int cyc;
        int req_cnt;
        int fault_cyc;
        @(negedge clk);
        bus.refund_amount = 11'd150; bus.stock_empty = 4'b0000; bus.eject_ack = 1'b0; bus.refund_valid = 1'b1;
        @(negedge clk);
        bus.refund_valid = 1'b0;
        req_cnt = 0; fault_cyc = -1;
        for (cyc = 1; cyc < 40; cyc++) begin
            if (bus.eject_req) req_cnt++;
            if (bus.fault && fault_cyc < 0) fault_cyc = cyc;
            @(negedge clk);
        end
        total++; if (req_cnt !== 16) begin bad++; $display("FAIL to_req_cycles got=%0d want=16", req_cnt); end
        total++; if (fault_cyc !== 18) begin bad++; $display("FAIL to_fault_cycle got=%0d want=18", fault_cyc); end
        total++; if (bus.fault !== 1'b1 || bus.eject_req !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL to_state fault=%b req=%b busy=%b want 1 0 0", bus.fault, bus.eject_req, bus.busy); end
        total++; if (bus.shortfall !== 11'd150) begin bad++; $display("FAIL to_shortfall got=%0d want=150", bus.shortfall); end
        bus.refund_valid = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (bus.refund_ready !== 1'b0 || bus.fault !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL to_sticky ready=%b fault=%b busy=%b want 0 1 0", bus.refund_ready, bus.fault, bus.busy); end
        bus.refund_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.fault !== 1'b0 || bus.refund_ready !== 1'b1) begin
            bad++; $display("FAIL to_cleared fault=%b ready=%b want 0 1", bus.fault, bus.refund_ready); end
    endtask

    initial begin
        test_reset();
        test_greedy_180();
        test_skip_empty_60();
        test_remainder_35();
        test_no_coin();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
